risc8_cdi_decode: RTL and testbench
===================================

Name: risc8_cdi_decode

Overview:
- Registered instruction decoder for the 8-bit RISC core.
- Each cycle it takes one fetched instruction byte and drives the control/datapath bundle: register addresses, ALU op, B-operand select, result select, write enable, memory strobes, stack/branch/system controls.
- Sits between fetch and the register file / ALU.
- Handles the two-byte CPY (load-immediate) sequence internally.

Parameters:
- none (fixed 8-bit ISA)

Ports:
- clk        in   1  core clock, rising edge
- rst        in   1  asynchronous, active-high reset
- instr      in   8  instruction or immediate byte
- instr_vld  in   1  instr valid this cycle
- alu_comp   in   3  ALU flags: [0] zero, [1] carry, [2] negative
- a1         out  2  operand A / destination register
- a2         out  2  operand B register
- a3         out  2  write-back register, always equal to a1
- imm        out  8  immediate byte
- alu_op     out  4  NONE=0 ADD=1 SUB=2 AND=3 OR=4 XOR=5 MUL=6 DIV=7 SL=8 SR=9 RA=10 RAS=11
- selb       out  2  NONE=0 REG=1 IMM=2 ONE=3
- selr       out  3  NONE=0 COM=1 IMM=2 ALUL=3 ALUH=4 MEMH=5 MEML=6 INTR=7
- rw_en      out  1  register write enable
- mem_rd     out  1  memory read strobe
- mem_wr     out  1  memory write strobe
- stk_op     out  2  NONE=0 PUSH=1 POP=2 COM=3
- br_taken   out  1  branch taken
- sys_en     out  1  system op valid
- sys_op     out  4  system op code (instr[3:0] of the 0xF class)
- illegal    out  1  undefined opcode

Behaviour:
- All outputs registered, one-cycle latency: instr sampled at edge N appears on outputs after edge N.
- Reset, and any cycle with instr_vld=0, gives the NOP bundle on the next cycle: every output 0. The FSM state holds while instr_vld=0.
- Field split:
  - op = instr[7:4]
  - a1 = instr[3:2]
  - a2 = instr[1:0]
  - a3 = a1
- Defaults unless stated: alu_op=NONE, selb=NONE, selr=NONE; rw_en, mem_*, stk_op, br_taken, sys_en and illegal all 0.
- FSM states: DEC and IMM; reset state is DEC.
- op=0x0:
  - a1!=a2 → MOVE: rw_en=1, selr=COM.
  - a1==a2 → CPYn with n=a1: outputs stay at defaults, FSM → IMM, n is latched.
- In IMM, the next valid byte is data, not an opcode:
  - imm=byte, selb=IMM, selr=IMM, rw_en=1, a1=a3=latched n, a2=0.
  - FSM → DEC.
- op=0x1..0xB: ALU register ops ADD, SUB, AND, OR, XOR, MUL, DIV, SLL, SRL, SRA, SRAS.
  - alu_op = op, using the ALU code order above.
  - selb=REG, selr=ALUL, rw_en=1.
- op=0xC: memory ops, selected by instr[1:0]; address register is a1.
  - 00 LWHI: mem_rd=1, selr=MEMH, rw_en=1.
  - 01 SWHI: mem_wr=1.
  - 10 LWLO: mem_rd=1, selr=MEML, rw_en=1.
  - 11 SWLO: mem_wr=1.
- op=0xD: selected by instr[1:0].
  - 00 INC: alu_op=ADD, selb=ONE, selr=ALUL, rw_en=1.
  - 01 DEC: alu_op=SUB, selb=ONE, selr=ALUL, rw_en=1.
  - 10 GETAH: selr=ALUH, rw_en=1.
  - 11 GETIF: selr=INTR, rw_en=1.
- op=0xE: selected by instr[1:0].
  - 00 PUSH: stk_op=1.
  - 01 POP: stk_op=2, selr=MEML, rw_en=1.
  - 10 COM: stk_op=3.
  - 11 BR cc: cc=instr[3:2]; br_taken = alu_comp[cc] for cc<3, br_taken=1 for cc=3. alu_comp is sampled in the same cycle as the BR byte.
- op=0xF, instr[3:0]=0..D: sys_en=1, sys_op=instr[3:0].
  - Codes in order: CALL, RET, JUMP, RETI, CLC, SETC, CLS, SETS, SSETS, CLN, SETN, SSETN, RJUMP, RBWI.
- 0xFE, 0xFF: NOP bundle with illegal=1.
- Reset asserted mid-CPY: FSM → DEC and the pending immediate is discarded.
- Only one of mem_rd / mem_wr is ever high; rw_en is never 1 together with mem_wr.

Test Plan:
- Reset, then instr=0x00 (CPY0) followed by 0x5A → first output cycle: all 0; second: a3=0, imm=0x5A, selr=IMM, selb=IMM, rw_en=1.
- 0x04 (MOVE r1←r0) → a1=1, a2=0, selr=COM, rw_en=1, alu_op=0.
- 0x11 then 0x21 → cycle 1: ADD, a1=0, a2=1, selb=REG, selr=ALUL; cycle 2: SUB, same fields.
- 0xC4 (LWHI r1) → mem_rd=1, selr=MEMH, rw_en=1. 0xC5 (SWHI r1) → mem_wr=1, rw_en=0.
- 0xE3 (BR cc=0) with alu_comp=001 → br_taken=1; with alu_comp=110 → br_taken=0. 0xEF → br_taken=1 for any alu_comp.
- 0xFF → illegal=1, all other outputs 0. 0xF0 → sys_en=1, sys_op=0.
- 0x00 sent, then rst pulsed, then 0x5A → 0x5A decodes as op=5 (XOR, a1=2, a2=2), not as an immediate.

Source files
------------

// File: rtl/risc8_cdi_decode.sv
// Registered instruction decoder for the 8-bit RISC core: one fetched byte in,
// one control/datapath bundle out a cycle later. Handles the two-byte CPY sequence.
module risc8_cdi_decode (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] instr,
    input  logic       instr_vld,
    input  logic [2:0] alu_comp,
    output logic [1:0] a1,
    output logic [1:0] a2,
    output logic [1:0] a3,
    output logic [7:0] imm,
    output logic [3:0] alu_op,
    output logic [1:0] selb,
    output logic [2:0] selr,
    output logic       rw_en,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic [1:0] stk_op,
    output logic       br_taken,
    output logic       sys_en,
    output logic [3:0] sys_op,
    output logic       illegal
);

    // instr is consumed on every rising edge where instr_vld=1; there is no
    // back-pressure. A cycle with instr_vld=0 yields the NOP bundle and holds state.
    typedef enum logic {ST_DEC = 1'b0, ST_IMM = 1'b1} state_t;

    localparam logic [3:0] ALU_NONE = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2;
    localparam logic [1:0] SELB_NONE = 2'd0, SELB_REG = 2'd1, SELB_IMM = 2'd2, SELB_ONE = 2'd3;
    localparam logic [2:0] SELR_NONE = 3'd0, SELR_COM = 3'd1, SELR_IMM = 3'd2, SELR_ALUL = 3'd3,
                           SELR_ALUH = 3'd4, SELR_MEMH = 3'd5, SELR_MEML = 3'd6, SELR_INTR = 3'd7;

    state_t     r_state, w_state_nxt;
    logic [1:0] r_n, w_n_nxt;

    logic [1:0] w_a1, w_a2, w_selb, w_stk_op;
    logic [7:0] w_imm;
    logic [3:0] w_alu_op, w_sys_op, w_op;
    logic [2:0] w_selr;
    logic       w_rw_en, w_mem_rd, w_mem_wr, w_br_taken, w_sys_en, w_illegal;

    logic [1:0] r_a1, r_a2, r_selb, r_stk_op;
    logic [7:0] r_imm;
    logic [3:0] r_alu_op, r_sys_op;
    logic [2:0] r_selr;
    logic       r_rw_en, r_mem_rd, r_mem_wr, r_br_taken, r_sys_en, r_illegal;

    assign w_op = instr[7:4];

    always_comb begin
        w_state_nxt = r_state;
        w_n_nxt     = r_n;
        w_a1        = 2'd0;
        w_a2        = 2'd0;
        w_imm       = 8'd0;
        w_alu_op    = ALU_NONE;
        w_selb      = SELB_NONE;
        w_selr      = SELR_NONE;
        w_rw_en     = 1'b0;
        w_mem_rd    = 1'b0;
        w_mem_wr    = 1'b0;
        w_stk_op    = 2'd0;
        w_br_taken  = 1'b0;
        w_sys_en    = 1'b0;
        w_sys_op    = 4'd0;
        w_illegal   = 1'b0;
        if (instr_vld) begin
            if (r_state == ST_IMM) begin
                // Second CPY byte is data for the latched register.
                w_a1        = r_n;
                w_imm       = instr;
                w_selb      = SELB_IMM;
                w_selr      = SELR_IMM;
                w_rw_en     = 1'b1;
                w_state_nxt = ST_DEC;
            end else if (instr == 8'hFE || instr == 8'hFF) begin
                w_illegal = 1'b1;
            end else if (w_op == 4'h0 && instr[3:2] == instr[1:0]) begin
                w_n_nxt     = instr[3:2];
                w_state_nxt = ST_IMM;
            end else begin
                w_a1 = instr[3:2];
                w_a2 = instr[1:0];
                case (w_op)
                    4'h0: begin
                        w_selr  = SELR_COM;
                        w_rw_en = 1'b1;
                    end
                    4'hC: begin
                        w_mem_rd = ~instr[0];
                        w_mem_wr = instr[0];
                        w_rw_en  = ~instr[0];
                        if (!instr[0]) w_selr = instr[1] ? SELR_MEML : SELR_MEMH;
                    end
                    4'hD: begin
                        w_rw_en = 1'b1;
                        case (instr[1:0])
                            2'b00: begin w_alu_op = ALU_ADD; w_selb = SELB_ONE; w_selr = SELR_ALUL; end
                            2'b01: begin w_alu_op = ALU_SUB; w_selb = SELB_ONE; w_selr = SELR_ALUL; end
                            2'b10: w_selr = SELR_ALUH;
                            default: w_selr = SELR_INTR;
                        endcase
                    end
                    4'hE: begin
                        case (instr[1:0])
                            2'b00: w_stk_op = 2'd1;
                            2'b01: begin w_stk_op = 2'd2; w_selr = SELR_MEML; w_rw_en = 1'b1; end
                            2'b10: w_stk_op = 2'd3;
                            default: begin
                                case (instr[3:2])
                                    2'd0: w_br_taken = alu_comp[0];
                                    2'd1: w_br_taken = alu_comp[1];
                                    2'd2: w_br_taken = alu_comp[2];
                                    default: w_br_taken = 1'b1;
                                endcase
                            end
                        endcase
                    end
                    4'hF: begin
                        w_sys_en = 1'b1;
                        w_sys_op = instr[3:0];
                    end
                    default: begin
                        w_alu_op = w_op;
                        w_selb   = SELB_REG;
                        w_selr   = SELR_ALUL;
                        w_rw_en  = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_DEC;
            r_n        <= 2'd0;
            r_a1       <= 2'd0;
            r_a2       <= 2'd0;
            r_imm      <= 8'd0;
            r_alu_op   <= ALU_NONE;
            r_selb     <= SELB_NONE;
            r_selr     <= SELR_NONE;
            r_rw_en    <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_stk_op   <= 2'd0;
            r_br_taken <= 1'b0;
            r_sys_en   <= 1'b0;
            r_sys_op   <= 4'd0;
            r_illegal  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_n        <= w_n_nxt;
            r_a1       <= w_a1;
            r_a2       <= w_a2;
            r_imm      <= w_imm;
            r_alu_op   <= w_alu_op;
            r_selb     <= w_selb;
            r_selr     <= w_selr;
            r_rw_en    <= w_rw_en;
            r_mem_rd   <= w_mem_rd;
            r_mem_wr   <= w_mem_wr;
            r_stk_op   <= w_stk_op;
            r_br_taken <= w_br_taken;
            r_sys_en   <= w_sys_en;
            r_sys_op   <= w_sys_op;
            r_illegal  <= w_illegal;
        end
    end

    assign a1       = r_a1;
    assign a2       = r_a2;
    assign a3       = r_a1;
    assign imm      = r_imm;
    assign alu_op   = r_alu_op;
    assign selb     = r_selb;
    assign selr     = r_selr;
    assign rw_en    = r_rw_en;
    assign mem_rd   = r_mem_rd;
    assign mem_wr   = r_mem_wr;
    assign stk_op   = r_stk_op;
    assign br_taken = r_br_taken;
    assign sys_en   = r_sys_en;
    assign sys_op   = r_sys_op;
    assign illegal  = r_illegal;

endmodule

// File: tb/tb_risc8_cdi_decode.sv
// Bench for risc8_cdi_decode: directed test-plan sequences with literal checks,
// then randomized bytes compared every cycle against a behavioural decode model.
module tb_risc8_cdi_decode;

    typedef struct packed {
        logic [1:0] a1;
        logic [1:0] a2;
        logic [1:0] a3;
        logic [7:0] imm;
        logic [3:0] alu_op;
        logic [1:0] selb;
        logic [2:0] selr;
        logic       rw_en;
        logic       mem_rd;
        logic       mem_wr;
        logic [1:0] stk_op;
        logic       br_taken;
        logic       sys_en;
        logic [3:0] sys_op;
        logic       illegal;
    } bundle_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] instr = 8'd0;
    logic       instr_vld = 1'b0;
    logic [2:0] alu_comp = 3'd0;
    logic [1:0] a1, a2, a3, selb, stk_op;
    logic [7:0] imm;
    logic [3:0] alu_op, sys_op;
    logic [2:0] selr;
    logic       rw_en, mem_rd, mem_wr, br_taken, sys_en, illegal;

    int n_checks = 0;
    int n_fail   = 0;

    logic [34:0] exp_q[$];
    logic        m_imm_pending = 1'b0;
    logic [1:0]  m_n = 2'd0;

    risc8_cdi_decode dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_vld(instr_vld), .alu_comp(alu_comp),
        .a1(a1), .a2(a2), .a3(a3), .imm(imm), .alu_op(alu_op), .selb(selb), .selr(selr),
        .rw_en(rw_en), .mem_rd(mem_rd), .mem_wr(mem_wr), .stk_op(stk_op),
        .br_taken(br_taken), .sys_en(sys_en), .sys_op(sys_op), .illegal(illegal)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic bundle_t actual();
        bundle_t b;
        b = '{a1: a1, a2: a2, a3: a3, imm: imm, alu_op: alu_op, selb: selb, selr: selr,
              rw_en: rw_en, mem_rd: mem_rd, mem_wr: mem_wr, stk_op: stk_op,
              br_taken: br_taken, sys_en: sys_en, sys_op: sys_op, illegal: illegal};
        return b;
    endfunction

    // Behavioural decode: mnemonic-level rules from the ISA tables.
    function automatic bundle_t model(input logic [7:0] b, input logic vld, input logic [2:0] f,
                                      input logic pending, input logic [1:0] n);
        bundle_t    e;
        logic [3:0] op;
        logic [1:0] x, y;
        logic [3:0] d_alu[4];
        logic [1:0] d_selb[4];
        logic [2:0] d_selr[4];
        d_alu  = '{4'd1, 4'd2, 4'd0, 4'd0};
        d_selb = '{2'd3, 2'd3, 2'd0, 2'd0};
        d_selr = '{3'd3, 3'd3, 3'd4, 3'd7};
        e  = '0;
        op = b[7:4];
        x  = b[3:2];
        y  = b[1:0];
        if (!vld) return e;
        if (pending) begin
            e.a1 = n; e.a3 = n; e.imm = b; e.selb = 2'd2; e.selr = 3'd2; e.rw_en = 1'b1;
            return e;
        end
        if (b >= 8'hFE) begin e.illegal = 1'b1; return e; end
        if (op == 4'd0 && x == y) return e;
        e.a1 = x; e.a2 = y; e.a3 = x;
        if (op == 4'd0) begin
            e.selr = 3'd1; e.rw_en = 1'b1;
        end else if (op <= 4'd11) begin
            e.alu_op = op; e.selb = 2'd1; e.selr = 3'd3; e.rw_en = 1'b1;
        end else if (op == 4'd12) begin
            if (y == 2'd0) begin e.mem_rd = 1'b1; e.selr = 3'd5; e.rw_en = 1'b1; end
            if (y == 2'd2) begin e.mem_rd = 1'b1; e.selr = 3'd6; e.rw_en = 1'b1; end
            if (y == 2'd1 || y == 2'd3) e.mem_wr = 1'b1;
        end else if (op == 4'd13) begin
            e.alu_op = d_alu[y]; e.selb = d_selb[y]; e.selr = d_selr[y]; e.rw_en = 1'b1;
        end else if (op == 4'd14) begin
            if (y == 2'd3) e.br_taken = (x == 2'd3) ? 1'b1 : f[x];
            else           e.stk_op = y + 2'd1;
            if (y == 2'd1) begin e.selr = 3'd6; e.rw_en = 1'b1; end
        end else begin
            e.sys_en = 1'b1; e.sys_op = b[3:0];
        end
        return e;
    endfunction

    // Model state and expected queue advance on the same edges the DUT samples.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_imm_pending <= 1'b0;
            m_n           <= 2'd0;
        end else begin
            exp_q.push_back(model(instr, instr_vld, alu_comp, m_imm_pending, m_n));
            if (instr_vld) begin
                if (m_imm_pending) m_imm_pending <= 1'b0;
                else if (instr[7:4] == 4'd0 && instr[3:2] == instr[1:0]) begin
                    m_imm_pending <= 1'b1;
                    m_n           <= instr[3:2];
                end
            end
        end
    end

    // scoreboard compare, every cycle on the falling edge
    always @(negedge clk) begin
        logic [34:0] e;
        if (rst) begin
            e = '0;
            exp_q.delete();
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end else begin
            e = '0;
        end
        n_checks++;
        if (actual() !== e) begin
            n_fail++;
            $display("FAIL bundle t=%0t actual=%h required=%h", $time, actual(), e);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // driver: inputs change 2 time units after a rising edge
    task automatic step(input logic [7:0] b, input logic v, input logic [2:0] f);
        instr = b; instr_vld = v; alu_comp = f;
        @(posedge clk); #2;
    endtask

    task automatic do_reset();
        rst = 1'b1; instr_vld = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    initial begin
        @(posedge clk); #2;
        do_reset();
        chk("reset_bundle", 32'(actual() != '0), 32'd0);

        step(8'h00, 1'b1, 3'd0);
        chk("cpy0_first_zero", 32'(actual() != '0), 32'd0);
        step(8'h5A, 1'b1, 3'd0);
        chk("cpy0_imm", {24'd0, imm}, 32'h5A);
        chk("cpy0_sel", {selb, selr, rw_en, a3}, {2'd2, 3'd2, 1'b1, 2'd0});

        step(8'h04, 1'b1, 3'd0);
        chk("move", {a1, a2, selr, rw_en, alu_op}, {2'd1, 2'd0, 3'd1, 1'b1, 4'd0});

        step(8'h11, 1'b1, 3'd0);
        chk("add", {alu_op, a1, a2, selb, selr}, {4'd1, 2'd0, 2'd1, 2'd1, 3'd3});
        step(8'h21, 1'b1, 3'd0);
        chk("sub", {alu_op, a1, a2, selb, selr}, {4'd2, 2'd0, 2'd1, 2'd1, 3'd3});

        step(8'hC4, 1'b1, 3'd0);
        chk("lwhi", {mem_rd, mem_wr, selr, rw_en}, {1'b1, 1'b0, 3'd5, 1'b1});
        step(8'hC5, 1'b1, 3'd0);
        chk("swhi", {mem_rd, mem_wr, rw_en}, {1'b0, 1'b1, 1'b0});

        step(8'hE3, 1'b1, 3'b001);
        chk("br_z_taken", {31'd0, br_taken}, 32'd1);
        step(8'hE3, 1'b1, 3'b110);
        chk("br_z_not", {31'd0, br_taken}, 32'd0);
        step(8'hEF, 1'b1, 3'b000);
        chk("br_always", {31'd0, br_taken}, 32'd1);

        step(8'hFF, 1'b1, 3'd0);
        chk("illegal", 32'(actual()), 32'd1);
        step(8'hF0, 1'b1, 3'd0);
        chk("sys_call", {sys_en, sys_op}, {1'b1, 4'd0});

        // CPY interrupted by vld=0 keeps waiting for data
        step(8'h0F, 1'b1, 3'd0);
        step(8'h77, 1'b0, 3'd0);
        chk("vld_low_nop", 32'(actual() != '0), 32'd0);
        step(8'h33, 1'b1, 3'd0);
        chk("cpy3_imm", {a1, a3, imm, rw_en}, {2'd3, 2'd3, 8'h33, 1'b1});

        // reset mid-CPY discards the pending immediate
        step(8'h00, 1'b1, 3'd0);
        do_reset();
        step(8'h5A, 1'b1, 3'd0);
        chk("rst_mid_cpy", {alu_op, a1, a2, selb, selr, rw_en},
            {4'd5, 2'd2, 2'd2, 2'd1, 3'd3, 1'b1});

        for (int i = 0; i < 3000; i++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) b = {4'd0, 2'($urandom_range(0, 3)), 2'b00} | {6'd0, b[3:2]};
            if ($urandom_range(0, 150) == 0) do_reset();
            step(b, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)));
            n_checks++;
            if ((mem_rd && mem_wr) || (rw_en && mem_wr)) begin
                n_fail++;
                $display("FAIL strobe_excl rd=%0b wr=%0b rw=%0b required exclusive", mem_rd, mem_wr, rw_en);
            end
        end

        step(8'h00, 1'b0, 3'd0);
        step(8'h00, 1'b0, 3'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
